rv_skid_buffer: RTL and testbench

//  Two-entry elastic (skid) stage with valid/ready handshakes on both sides.

---
 rtl/rv_pipe_pkg.sv | 15 +
 rtl/rv_skid_slot.sv | 28 ++
 rtl/rv_skid_buffer.sv | 104 ++++++++++
 tb/tb_rv_skid_buffer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared encodings for the elastic pipeline stages.
// The skid-buffer state values are fixed so that other stages can decode them.
package rv_pipe_pkg;

   localparam logic [1:0] SKID_EMPTY = 2'd0;
   localparam logic [1:0] SKID_BUSY  = 2'd1;
   localparam logic [1:0] SKID_FULL  = 2'd2;

   typedef enum logic [1:0] {
      ST_EMPTY = SKID_EMPTY,
      ST_BUSY  = SKID_BUSY,
      ST_FULL  = SKID_FULL
   } skid_state_t;

endpackage

// File: rtl/rv_skid_slot.sv
// One payload register of the skid buffer: load enable, optional reset.
// With RESET_DATA = 0 the register has no reset and only loads while out of reset.
module rv_skid_slot #(
   parameter int DATAW      = 8,
   parameter bit RESET_DATA = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [DATAW-1:0] d,
   output logic [DATAW-1:0] q
);

   generate
      if (RESET_DATA) begin : g_rst
         always_ff @(posedge clk or negedge reset) begin
            if (!reset)    q <= '0;
            else if (load) q <= d;
         end
      end else begin : g_norst
         // Loads are already impossible in reset (no handshake); gating keeps that explicit.
         always_ff @(posedge clk) begin
            if (load && reset) q <= d;
         end
      end
   endgenerate

endmodule

// File: rtl/rv_skid_buffer.sv
// Two-entry valid/ready skid buffer; ready_in is decoded from registered state only.
// Optional stall counter port perf_stalls when RV_SKID_PERF_EN is defined.
module rv_skid_buffer
   import rv_pipe_pkg::*;
#(
   parameter int DATAW      = 8,
   parameter bit RESET_DATA = 1'b0,
   parameter int PERFW      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   input  logic [DATAW-1:0] data_in,
   output logic             ready_in,
   output logic             valid_out,
   output logic [DATAW-1:0] data_out,
   input  logic             ready_out
`ifdef RV_SKID_PERF_EN
   ,
   output logic [PERFW-1:0] perf_stalls
`endif
);

   skid_state_t      state, state_nxt;
   logic             in_xfer, out_xfer;
   logic             load_main, load_skid, main_from_skid;
   logic [DATAW-1:0] skid_q, main_d;

   assign valid_out = (state != ST_EMPTY);
   assign ready_in  = (state != ST_FULL) & reset;
   assign in_xfer   = valid_in & ready_in;
   assign out_xfer  = valid_out & ready_out;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      case (state)
         ST_EMPTY: begin
            if (in_xfer) begin
               state_nxt = ST_BUSY;
               load_main = 1'b1;
            end
         end
         ST_BUSY: begin
            if (in_xfer && !out_xfer) begin
               state_nxt = ST_FULL;
               load_skid = 1'b1;
            end else if (!in_xfer && out_xfer) begin
               state_nxt = ST_EMPTY;
            end else if (in_xfer && out_xfer) begin
               load_main = 1'b1;
            end
         end
         ST_FULL: begin
            // valid_in is ignored here: ready_in is low.
            if (ready_out) begin
               state_nxt      = ST_BUSY;
               load_main      = 1'b1;
               main_from_skid = 1'b1;
            end
         end
         default: state_nxt = ST_EMPTY;
      endcase
   end

   assign main_d = main_from_skid ? skid_q : data_in;

   rv_skid_slot #(.DATAW(DATAW), .RESET_DATA(RESET_DATA)) u_main (
      .clk   (clk),
      .reset (reset),
      .load  (load_main),
      .d     (main_d),
      .q     (data_out)
   );

   rv_skid_slot #(.DATAW(DATAW), .RESET_DATA(RESET_DATA)) u_skid (
      .clk   (clk),
      .reset (reset),
      .load  (load_skid),
      .d     (data_in),
      .q     (skid_q)
   );

`ifdef RV_SKID_PERF_EN
   logic [PERFW-1:0] stall_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         stall_cnt <= '0;
      else if ((valid_out && !ready_out) || (valid_in && !ready_in))
         stall_cnt <= stall_cnt + PERFW'(1);
   end

   assign perf_stalls = stall_cnt;
`endif

endmodule

// File: tb/tb_rv_skid_buffer.sv
// Bench for rv_skid_buffer: directed steps plus random traffic against a queue model.
// Define RV_SKID_PERF_EN to also check the stall counter.
module tb_rv_skid_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_in;
   logic [7:0]  data_in;
   logic        ready_in;
   logic        valid_out;
   logic [7:0]  data_out;
   logic        ready_out;
`ifdef RV_SKID_PERF_EN
   logic [31:0] perf_stalls;
`endif

   rv_skid_buffer #(.DATAW(8), .RESET_DATA(1'b0), .PERFW(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .valid_in    (valid_in),
      .data_in     (data_in),
      .ready_in    (ready_in),
      .valid_out   (valid_out),
      .data_out    (data_out),
      .ready_out   (ready_out)
`ifdef RV_SKID_PERF_EN
      ,
      .perf_stalls (perf_stalls)
`endif
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   logic [7:0]  mq[$];      // model contents, head = data_out
   int unsigned mperf = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("valid_out", {31'd0, valid_out}, {31'd0, mq.size() != 0});
      chk("ready_in", {31'd0, ready_in}, {31'd0, (reset === 1'b1) && mq.size() < 2});
      if (mq.size() != 0) chk("data_out", {24'd0, data_out}, {24'd0, mq[0]});
`ifdef RV_SKID_PERF_EN
      chk("perf_stalls", perf_stalls, mperf);
`endif
   endtask

   // Drive one cycle of inputs, check the pre-edge outputs, then advance the model.
   task automatic step(input logic vi, input logic [7:0] d, input logic ro);
      bit full, emp;
      @(negedge clk);
      valid_in  = vi;
      data_in   = d;
      ready_out = ro;
      #1;
      check_outputs();
      full = (mq.size() == 2);
      emp  = (mq.size() == 0);
      @(posedge clk);
      if (reset) begin
         if ((!emp && !ro) || (vi && full)) mperf++;
         if (!emp && ro) void'(mq.pop_front());
         if (vi && !full) mq.push_back(d);
      end
   endtask

   initial begin
      // 1. reset held with valid_in high
      reset     = 1'b0;
      valid_in  = 1'b1;
      data_in   = 8'h77;
      ready_out = 1'b0;
      #12;
      chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
      chk("rst_ready_in", {31'd0, ready_in}, 32'd0);
`ifdef RV_SKID_PERF_EN
      chk("rst_perf", perf_stalls, 32'd0);
`endif
      @(negedge clk);
      valid_in = 1'b0;
      reset    = 1'b1;
      #1;
      chk("rel_ready_in", {31'd0, ready_in}, 32'd1);
      chk("rel_valid_out", {31'd0, valid_out}, 32'd0);

      // 2. streaming 0x01..0x10 with ready_out high
      for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b1);
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1);

      // 3. stall: two entries with consumer blocked, then drain
      step(1'b1, 8'hA5, 1'b0);
      step(1'b1, 8'h5A, 1'b0);
      step(1'b1, 8'hEE, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      chk("full_ready_in", {31'd0, ready_in}, 32'd0);
      chk("full_data_out", {24'd0, data_out}, 32'h0000_00A5);
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1);

      // 4. simultaneous in and out while BUSY
      step(1'b1, 8'h33, 1'b1);
      step(1'b1, 8'h44, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1);

      // 5. reset while FULL drops valid_out without waiting for a clock
      step(1'b1, 8'h11, 1'b0);
      step(1'b1, 8'h22, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("async_valid_out", {31'd0, valid_out}, 32'd0);
      chk("async_ready_in", {31'd0, ready_in}, 32'd0);
      mq.delete();
      mperf = 0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("post_rst_valid_out", {31'd0, valid_out}, 32'd0);
      chk("post_rst_ready_in", {31'd0, ready_in}, 32'd1);

`ifdef RV_SKID_PERF_EN
      // 6. seven stalled cycles with valid_out high
      step(1'b1, 8'hC3, 1'b0);
      for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b0);
      @(negedge clk);
      #1;
      chk("perf_seven", perf_stalls, 32'd7);
`endif
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1);

      // random traffic with varying back-pressure
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0 || i > 200 && i < 260));
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
      @(negedge clk);
      #1;
      chk("drained_valid_out", {31'd0, valid_out}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
